// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised sync FIFO: depth derivation, threshold checks,
// and the status bit order used when the flags are packed onto uio_out.
package fifo_pkg;

  localparam int STS_EMPTY     = 0;
  localparam int STS_FULL      = 1;
  localparam int STS_UNDERFLOW = 2;
  localparam int STS_OVERFLOW  = 3;
  localparam int STS_AE        = 4;
  localparam int STS_AF        = 5;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic bit thresh_ok(input int af, input int ae, input int depth);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

  // {2'b0, almost_full, almost_empty, overflow, underflow, full, empty}
  function automatic logic [7:0] pack_status(input logic af, input logic ae,
                                             input logic ovf, input logic udf,
                                             input logic full, input logic empty);
    return {2'b00, af, ae, ovf, udf, full, empty};
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// No reset on the array; contents are only meaningful behind the FIFO pointers.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with level, threshold flags and sticky overflow/underflow.
// FWFT=1: head word visible 1 cycle after push; FWFT=0: 1-cycle registered read; full rejects push.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int FWFT       = 1,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int LVL_W = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LVL    = LVL_W'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_LVL    = LVL_W'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = LVL_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  if (!thresh_ok(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
    $error("fifo_sync_param: AF_THRESH/AE_THRESH out of range for DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Flags decode only the registered level, so they change cleanly after each edge.
  assign empty        = (level_q == '0);
  assign full         = (level_q == DEPTH_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // Clear first so a same-cycle error still leaves the flag set.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en & full)  overflow_d  = 1'b1;
    if (rd_en & empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = ram_rd_data;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    always_comb begin
      rd_data_d  = pop_ok ? ram_rd_data : rd_data_q;
      rd_valid_d = pop_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: FWFT=1 instance for most behaviour, FWFT=0 instance
// for the registered-read path; vectors and sequences carry hand-computed expectations.
module tb_fifo_sync_param;

  logic       clk;
  logic       rst_n;

  logic       wr_en, rd_en, err_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [5:0] level;

  logic       wr_en0, rd_en0, err_clr0;
  logic [7:0] wr_data0, rd_data0;
  logic       rd_valid0, empty0, full0, almost_empty0, almost_full0, overflow0, underflow0;
  logic [5:0] level0;

  int checks = 0;
  int errors = 0;

  fifo_sync_param dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  fifo_sync_param #(.FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .level(level0), .empty(empty0), .full(full0),
    .almost_empty(almost_empty0), .almost_full(almost_full0), .overflow(overflow0),
    .underflow(underflow0), .err_clr(err_clr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    logic       chk_d;
    logic [7:0] exp_d;
    logic       exp_v;
    logic [5:0] exp_lvl;
    logic [5:0] exp_flags; // {af, ae, ovf, udf, full, empty}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {almost_full, almost_empty, overflow, underflow, full, empty};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    err_clr = clr;
  endtask

  task automatic chk_thresh(input string name, input int lvl);
    chk({name, "_level"}, 32'(level), 32'(lvl));
    chk({name, "_af"}, 32'(almost_full), 32'(lvl >= 28));
    chk({name, "_ae"}, 32'(almost_empty), 32'(lvl <= 4));
    chk({name, "_full"}, 32'(full), 32'(lvl == 32));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 6'd1, 6'b010000};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 6'd2, 6'b010000};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 6'd3, 6'b010000};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 6'd2, 6'b010000};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 6'd1, 6'b010000};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010001};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010101};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010001};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010101};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010001};
    vecs[10] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 6'd1, 6'b010100};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010101};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 6'b010001};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    wr_en0 = 1'b0; wr_data0 = 8'h00; rd_en0 = 1'b0; err_clr0 = 1'b0;
    step();
    step();
    chk("reset_flags", 32'(flags()), 32'(6'b010001));
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data0", 32'(rd_data0), 32'h00);
    chk("reset_rd_valid0", 32'(rd_valid0), 32'd0);
    rst_n = 1'b1;

    // Basic push/pop, underflow and err_clr precedence.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
      step();
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_lvl));
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_v));
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_d));
    end

    // Fill to full and watch thresholds.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step();
      chk_thresh($sformatf("fill%0d", i), i + 1);
      chk($sformatf("fill%0d_head", i), 32'(rd_data), 32'h40);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    step();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd32);
    chk("ovf_head", 32'(rd_data), 32'h40);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Push+pop while full: pop wins, push rejected.
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    chk("full_both_level", 32'(level), 32'd31);
    chk("full_both_ovf", 32'(overflow), 32'd1);
    chk("full_both_full", 32'(full), 32'd0);
    for (int j = 0; j < 31; j++) begin
      chk($sformatf("drain%0d_data", j), 32'(rd_data), 32'(8'h41 + j));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Push+pop while empty: push only, underflow set.
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    step();
    chk("empty_both_level", 32'(level), 32'd1);
    chk("empty_both_udf", 32'(underflow), 32'd1);
    chk("empty_both_valid", 32'(rd_valid), 32'd1);
    chk("empty_both_data", 32'(rd_data), 32'h99);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    step();
    chk("empty_both_clr", 32'({overflow, underflow, empty}), 32'b001);

    // Steady-state streaming at level 10 across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'(k), 1'b0, 1'b0);
      step();
    end
    chk("stream_prefill", 32'(level), 32'd10);
    for (int j = 0; j < 40; j++) begin
      chk($sformatf("stream%0d_data", j), 32'(rd_data), 32'(j));
      drive(1'b1, 8'(10 + j), 1'b1, 1'b0);
      step();
      chk($sformatf("stream%0d_level", j), 32'(level), 32'd10);
    end
    for (int j = 40; j < 50; j++) begin
      chk($sformatf("stream_tail%0d", j), 32'(rd_data), 32'(j));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    chk("stream_empty", 32'(empty), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Registered-read instance.
    wr_en0 = 1'b1; wr_data0 = 8'hA5;
    step();
    wr_en0 = 1'b0;
    chk("std_push_valid", 32'(rd_valid0), 32'd0);
    chk("std_push_level", 32'(level0), 32'd1);
    rd_en0 = 1'b1;
    step();
    rd_en0 = 1'b0;
    chk("std_pop_data", 32'(rd_data0), 32'hA5);
    chk("std_pop_valid", 32'(rd_valid0), 32'd1);
    step();
    chk("std_idle_valid", 32'(rd_valid0), 32'd0);
    chk("std_idle_data", 32'(rd_data0), 32'hA5);
    rd_en0 = 1'b1;
    step();
    rd_en0 = 1'b0;
    chk("std_udf_valid", 32'(rd_valid0), 32'd0);
    chk("std_udf_flag", 32'(underflow0), 32'd1);
    chk("std_udf_data", 32'(rd_data0), 32'hA5);

    // Asynchronous reset mid-cycle at level 5 with underflow pending.
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_udf", 32'(underflow), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_flags", 32'(flags()), 32'(6'b010001));
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_data0", 32'(rd_data0), 32'h00);
    step();
    rst_n = 1'b1;
    drive(1'b1, 8'h7E, 1'b0, 1'b0);
    step();
    chk("post_rst_level", 32'(level), 32'd1);
    chk("post_rst_data", 32'(rd_data), 32'h7E);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_empty", 32'({empty, underflow}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
